// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared types and helpers for the SPI receive path.
//   spi_mode_t      : SPI mode encoding {CPOL,CPHA}
//   sample_on_rise  : 1 when the mode samples MISO on the rising sclk edge
// -----------------------------------------------------------------------------
package spi_pkg;

  typedef enum logic [1:0] {
    MODE0 = 2'd0,
    MODE1 = 2'd1,
    MODE2 = 2'd2,
    MODE3 = 2'd3
  } spi_mode_t;

  // Leading edge samples when CPHA=0; the leading edge is rising when CPOL=0.
  // Both cases reduce to CPOL XNOR CPHA.
  function automatic logic sample_on_rise(input spi_mode_t mode);
    logic [1:0] m;
    m = mode;
    return m[1] ~^ m[0];
  endfunction

endpackage

// File: rtl/spi_rx_deser_if.sv
// -----------------------------------------------------------------------------
// spi_rx_deser_if
// Response side of the SPI receive deserialiser.
//   rsps        : last completed word (holding register)
//   rsps_valid  : rsps holds an unconsumed word
//   rsps_ready  : consumer accepts rsps when rsps_valid is also high
//   done        : one-cycle pulse per completed word
//   busy        : a word is partially received
//   overrun     : sticky, a word completed while the previous one was unconsumed
// master = deserialiser, slave = consumer.
// -----------------------------------------------------------------------------
interface spi_rx_deser_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] rsps;
  logic              rsps_valid;
  logic              rsps_ready;
  logic              done;
  logic              busy;
  logic              overrun;

  modport master (
    output rsps,
    output rsps_valid,
    input  rsps_ready,
    output done,
    output busy,
    output overrun
  );

  modport slave (
    input  rsps,
    input  rsps_valid,
    output rsps_ready,
    input  done,
    input  busy,
    input  overrun
  );

endinterface

// File: rtl/spi_rx_deser_sync_edge_det.sv
// -----------------------------------------------------------------------------
// sync_edge_det
// Two-flop synchroniser for an asynchronous pin, plus rise/fall detection
// against the registered previous synchronised value.
//   clk, rst  : system clock, synchronous active-high reset
//   async_i   : asynchronous input pin
//   sync_out  : synchronised level (2 clk edges after the pin)
//   rise/fall : one-cycle edge strobes, acted on at the 3rd clk edge
// -----------------------------------------------------------------------------
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic sync_out,
  output logic rise,
  output logic fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  // Synchroniser chain and edge-detect history flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign sync_out = sync_q;
  assign rise     = sync_q & ~prev_q;
  assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/spi_rx_deser.sv
// -----------------------------------------------------------------------------
// spi_rx_deser
// SPI receive deserialiser. Oversamples sclk/rx on clk, shifts DATA_W-bit
// words in any SPI mode, MSB- or LSB-first, and presents each word through a
// valid/ready holding register with done/busy/overrun status.
//   clk, rst : system clock, synchronous active-high reset
//   start    : frame active (level); low aborts any partial word
//   mode     : SPI mode, captured on the start rising edge
//   sclk, rx : asynchronous SPI pins
//   rsp      : response interface (master side)
// -----------------------------------------------------------------------------
module spi_rx_deser
  import spi_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  spi_mode_t             mode,
  input  logic                  sclk,
  input  logic                  rx,
  spi_rx_deser_if.master        rsp
);

  localparam int                CNT_W    = $clog2(DATA_W);
  localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0]  CNT_ZERO = CNT_W'(0);
  localparam logic [DATA_W-1:0] WORD_ZERO = DATA_W'(0);

  // Pin synchronisation
  logic sclk_sync_unused_s;
  logic sclk_rise_s;
  logic sclk_fall_s;
  logic rx_sync_s;
  logic rx_rise_unused_s;
  logic rx_fall_unused_s;

  sync_edge_det u_sclk_sync (
    .clk      (clk),
    .rst      (rst),
    .async_i  (sclk),
    .sync_out (sclk_sync_unused_s),
    .rise     (sclk_rise_s),
    .fall     (sclk_fall_s)
  );

  // rx only needs the synchronised level; it shares the sclk latency so the
  // data/clock alignment seen at the pins is preserved.
  sync_edge_det u_rx_sync (
    .clk      (clk),
    .rst      (rst),
    .async_i  (rx),
    .sync_out (rx_sync_s),
    .rise     (rx_rise_unused_s),
    .fall     (rx_fall_unused_s)
  );

  // State
  logic              start_q;
  spi_mode_t         mode_q,       mode_d;
  logic [CNT_W-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [DATA_W-1:0] shreg_q,      shreg_d;
  logic [DATA_W-1:0] rsps_q,       rsps_d;
  logic              rsps_valid_q, rsps_valid_d;
  logic              done_q,       done_d;
  logic              busy_q,       busy_d;
  logic              overrun_q,    overrun_d;

  // Decode
  logic              start_rise_s;
  logic              sample_s;
  logic              shift_en_s;
  logic              word_done_s;
  logic [DATA_W-1:0] shreg_next_s;

  // Sample-edge decode and the shifted word including the current bit.
  always_comb begin
    start_rise_s = start & ~start_q;
    if (sample_on_rise(mode_q)) begin
      sample_s = sclk_rise_s;
    end else begin
      sample_s = sclk_fall_s;
    end
    // mode_q is only valid from the cycle after the start rise, so an edge in
    // the start-rise cycle is discarded.
    shift_en_s = start & ~start_rise_s & sample_s;
    if (MSB_FIRST) begin
      shreg_next_s = {shreg_q[DATA_W-2:0], rx_sync_s};
    end else begin
      shreg_next_s = {rx_sync_s, shreg_q[DATA_W-1:1]};
    end
    word_done_s = shift_en_s & (bit_cnt_q == LAST_BIT);
  end

  // Next-state logic for counter, shifter, holding register and flags.
  always_comb begin
    if (start_rise_s) begin
      mode_d = mode;
    end else begin
      mode_d = mode_q;
    end

    if (!start) begin
      bit_cnt_d = CNT_ZERO;
      shreg_d   = WORD_ZERO;
      busy_d    = 1'b0;
    end else if (word_done_s) begin
      bit_cnt_d = CNT_ZERO;
      shreg_d   = WORD_ZERO;
      busy_d    = 1'b0;
    end else if (shift_en_s) begin
      bit_cnt_d = bit_cnt_q + CNT_ONE;
      shreg_d   = shreg_next_s;
      busy_d    = 1'b1;
    end else begin
      bit_cnt_d = bit_cnt_q;
      shreg_d   = shreg_q;
      busy_d    = busy_q;
    end

    // A completion wins over a same-cycle accept so the new word stays valid.
    if (word_done_s) begin
      rsps_d       = shreg_next_s;
      rsps_valid_d = 1'b1;
      done_d       = 1'b1;
    end else if (rsps_valid_q && rsp.rsps_ready) begin
      rsps_d       = rsps_q;
      rsps_valid_d = 1'b0;
      done_d       = 1'b0;
    end else begin
      rsps_d       = rsps_q;
      rsps_valid_d = rsps_valid_q;
      done_d       = 1'b0;
    end

    if (start_rise_s) begin
      overrun_d = 1'b0;
    end else if (word_done_s && rsps_valid_q && !rsp.rsps_ready) begin
      overrun_d = 1'b1;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      start_q      <= 1'b0;
      mode_q       <= MODE0;
      bit_cnt_q    <= CNT_ZERO;
      shreg_q      <= WORD_ZERO;
      rsps_q       <= WORD_ZERO;
      rsps_valid_q <= 1'b0;
      done_q       <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      start_q      <= start;
      mode_q       <= mode_d;
      bit_cnt_q    <= bit_cnt_d;
      shreg_q      <= shreg_d;
      rsps_q       <= rsps_d;
      rsps_valid_q <= rsps_valid_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rsp.rsps       = rsps_q;
  assign rsp.rsps_valid = rsps_valid_q;
  assign rsp.done       = done_q;
  assign rsp.busy       = busy_q;
  assign rsp.overrun    = overrun_q;

endmodule

// File: doc/spi_rx_deser.md
# spi_rx_deser

Parametrised SPI receive deserialiser for the SPI host: oversamples `sclk` and `miso` on the system clock, shifts in `DATA_W`-bit words in any of the four SPI modes, MSB- or LSB-first, and presents each word through a valid/ready holding register. It supports back-to-back words inside one active frame, discards a partial word on abort, and flags overrun. It sits between the SPI pin interface and the host command/response controller.

## Interface
- `DATA_W`, default 8: word width in bits, legal range 2..32.
- `MSB_FIRST`, default 1: 1 means the first received bit lands in bit `DATA_W-1`; 0 means it lands in bit 0.
- `clk` input, 1: system clock, the only clock in the block.
- `rst` input, 1: reset, synchronous to `clk`, active-high.
- `start` input, 1: frame active. It is level-sensitive. Low clears the frame.
- `mode` input, 2: SPI mode {CPOL,CPHA}. Captured on the `start` rising edge.
- `sclk` input, 1: serial clock from the pin. Asynchronous to `clk`.
- `rx` input, 1: serial data (MISO) from the pin. Asynchronous to `clk`.
- `rsps` output, `DATA_W`: holding register containing the last completed word.
- `rsps_valid` output, 1: `rsps` holds an unconsumed word.
- `rsps_ready` input, 1: consumer accepts `rsps` on any cycle where `rsps_valid` and `rsps_ready` are both high.
- `done` output, 1: one-cycle pulse on each word completion.
- `busy` output, 1: a frame is active and a word is partially received.
- `overrun` output, 1: sticky flag. Set when a word completes while an unconsumed word is still held.

## Operation
- **Synchronisation:**
  - `sclk` and `rx` each pass through a 2-flop synchroniser.
  - Edge detection compares the synced `sclk` with its registered previous value.
- **Sample edge:** decoded from the captured mode.
  - Modes 0 and 3 sample on the synced `sclk` rising edge.
  - Modes 1 and 2 sample on the synced `sclk` falling edge.
- **Shifting:**
  - On each sample edge while `start` is high, the synced `rx` shifts into `shreg`.
  - Direction is set by `MSB_FIRST`.
  - `bit_cnt` increments; its width is `$clog2(DATA_W)`.
- **Word completion:** the sample edge with `bit_cnt == DATA_W-1`.
  - `rsps` is loaded with the completed word, including the current bit.
  - `rsps_valid` is set to 1 and `done` pulses.
  - `bit_cnt` wraps to 0 and reception continues with the next word if `start` stays high.
- **Handshake:**
  - `rsps_valid` clears on the cycle after `rsps_valid && rsps_ready`.
  - `rsps` holds its value until the next word completes.
- **Simultaneous accept and completion:** the new word loads, `rsps_valid` stays 1, and `overrun` is not set.
- **Overrun:**
  - Condition: a word completes while `rsps_valid` is 1 and `rsps_ready` is 0.
  - The new word overwrites `rsps` and `overrun` is set.
  - `overrun` clears only on `rst` or on a `start` rising edge.
- **Abort (`start` falls mid-word):**
  - `bit_cnt` and `shreg` are cleared and the partial word is discarded.
  - `rsps` and `rsps_valid` are left untouched.
- **Mode changes:** changes on `mode` while `start` is high are ignored.
- **Sample edge on the `start` rising cycle:** ignored. The first counted edge comes one cycle later.
- **Reset values:** all of the following clear on `rst`:
  - `rsps` = 0, `rsps_valid` = 0, `done` = 0, `busy` = 0, `overrun` = 0.
  - `bit_cnt`, `shreg`, captured mode and synchroniser flops.
  - `rst` takes priority over every other event.

## Timing
- **Pin-to-sample latency:** a pin edge on `sclk` is acted on 3 `clk` edges later (2 synchroniser stages plus 1 edge-detect stage). `rx` sees the same delay, so data/clock alignment is preserved.
- **Sclk constraint:** `sclk` high and low phases must each last at least 3 `clk` periods. Faster `sclk` is unsupported and loses bits.
- **Completion outputs:** `done` and `rsps_valid` rise on the `clk` edge that registers the final sample. `rsps` is valid in the same cycle.
- **Busy:** high from the first sample of a word until completion. It is low in the cycle after completion until the next sample edge.
- **Throughput:** one word per `DATA_W` `sclk` periods, with no dead cycles between words.

## Structure
- **Shared package `spi_pkg`:**
  - `spi_mode_t`, a 2-bit enum: MODE0..MODE3.
  - Function `sample_on_rise(mode)`, which returns CPOL XNOR CPHA.
- **Sub-module `sync_edge_det`:**
  - 2-flop synchroniser plus rise/fall detect.
  - Outputs: `sync_out`, `rise`, `fall`.
  - Instantiated for `sclk`; `rx` uses its `sync_out`-only path.
- **Top level:** counter, shift register, holding register, handshake and flags.

## Test plan
- **Basic mode 0:** `DATA_W=8`, MSB-first, mode 0, send 0xA5 with `sclk` at `clk`/8 -> `done` pulses once, `rsps`=0xA5, `rsps_valid`=1, `overrun`=0.
- **All modes and bit order:** send 0x3C in each of modes 0..3, with `MSB_FIRST=0` -> `rsps`=0x3C in all four modes.
- **Back-to-back with ready held high:** two words 0x12 then 0x34, `rsps_ready` held 1 -> two `done` pulses exactly 8 `sclk` periods apart, final `rsps`=0x34, `overrun`=0.
- **Overrun:** same two words with `rsps_ready`=0 -> `rsps`=0x34 and `overrun`=1. `overrun` clears on the next `start` rise.
- **Abort:** drop `start` after 5 bits, then send a full word 0xF0 -> no `done` pulse for the partial word, `rsps`=0xF0, `busy`=0 while `start` is low.
- **Reset mid-word and width:** assert `rst` mid-word -> all outputs return to 0 next cycle. Also run `DATA_W=16` with 0xBEEF -> `rsps`=0xBEEF.
